cache_axi_rd_arb: RTL and testbench
===================================

# cache_axi_rd_arb

Read-channel arbiter between the instruction-cache burst port and the data-cache burst port, producing the single AXI4 read master that leaves the CPU core. It sits directly downstream of the instruction cache's refill interface (araddr/arlen/arsize/arvalid/arready, rdata/rlast/rvalid/rready) and an identically shaped data-cache port. It holds one outstanding burst at a time and routes the R beats back to the client that owns it. Round-robin grant, with a protocol checker on burst length and ID.

## Interface
- `ID_W`, 4: AXI ID width.
- `INST_ID`, 0: ARID and expected RID for instruction bursts.
- `DATA_ID`, 1: ARID and expected RID for data bursts.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_araddr`/`d_araddr`  in  32  client burst start address.
- `i_arlen`/`d_arlen`  in  8  client beats-1.
- `i_arsize`/`d_arsize`  in  3  client bytes-per-beat code.
- `i_arvalid`/`d_arvalid`  in  1  client request; held until the client's arready.
- `i_arready`/`d_arready`  out  1  request accepted (one-cycle pulse).
- `i_rdata`/`d_rdata`  out  32  beat data.
- `i_rlast`/`d_rlast`  out  1  final beat.
- `i_rvalid`/`d_rvalid`  out  1  beat valid.
- `i_rready`/`d_rready`  in  1  client beat ready.
- `m_arid`  out  ID_W  AXI AR ID.
- `m_araddr`  out  32  AXI AR address.
- `m_arlen`  out  8  AXI AR length.
- `m_arsize`  out  3  AXI AR size.
- `m_arburst`  out  2  AXI AR burst type.
- `m_arvalid`/`m_arready`  out/in  1  AXI AR handshake.
- `m_rid`  in  ID_W  AXI R ID.
- `m_rdata`  in  32  AXI R data.
- `m_rresp`  in  2  AXI R response.
- `m_rlast`  in  1  AXI R last.
- `m_rvalid`/`m_rready`  in/out  1  AXI R handshake.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- FSM states and transitions:
  - IDLE: select a client, pulse its arready, latch its addr/len/size, then go to AR.
  - AR: hold `m_arvalid`=1 with the latched fields stable. On `m_arready` go to R.
  - R: forward beats. On an `m_rvalid & m_rready & m_rlast` handshake go to IDLE.
- Grant policy:
  - Only one client requesting: grant it.
  - Both requesting: grant the client not granted last. `last_grant` resets to instruction, so data wins the first tie.
- AR fields:
  - `m_arid` is INST_ID or DATA_ID according to the grant.
  - `m_arburst` is always 2'b01 (INCR).
  - The latched fields are registered outputs and do not follow client inputs after the grant.
- R routing in R state, for the granted client:
  - `x_rvalid` = `m_rvalid`; `x_rdata` = `m_rdata`; `x_rlast` = `m_rlast`; `m_rready` = `x_rready`.
  - The non-granted client sees `rvalid`=0 and `rlast`=0. Its rdata is don't-care, driven as `m_rdata`.
  - Outside R: `m_rready`=0 and both client `rvalid`=0.
- Beat counter (8 bits): cleared on entry to R, incremented on each R handshake.
- `err` sets on any of:
  - an `m_rlast` handshake with counter ≠ latched len;
  - a non-last handshake with counter == latched len;
  - an `m_rid` mismatch on a handshake;
  - `m_rresp` ≠ 2'b00 on a handshake.
- `err` does not change routing: beats are still forwarded and the FSM still exits on `m_rlast`.

## Timing
- Reset values:
  - state IDLE;
  - `m_arvalid`, `m_rready`, both client arready/rvalid/rlast: 0;
  - `m_araddr`, `m_arlen`, `m_arsize`, `m_arid`: 0;
  - `m_arburst`: 2'b01;
  - `err`: 0; counter: 0.
- Client arready is combinational in IDLE, in the same cycle the client arvalid is seen (cycle t). `m_arvalid`=1 from t+1.
- The AR handshake in cycle u gives R state from u+1. Earliest beat forwarding is u+1, zero-cycle pass-through.
- After the rlast handshake in cycle v, IDLE is entered at v+1. A new client arready can occur at v+1 and `m_arvalid` at v+2.
- A client arvalid that is not granted stays pending; it is never dropped.
- Reset asserted mid-burst: immediate return to reset values, and remaining beats are not absorbed. The interconnect is reset together with the core.

## Structure
- Shared package constants:
  - FSM encodings IDLE=2'b00, AR=2'b01, R=2'b10;
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00;
  - default INST_ID and DATA_ID.
- The round-robin two-way grant is one natural sub-module, `rr_arb2`: req[1:0], advance, gnt[1:0], with `last_grant` internal.

## Test plan
- Instruction only: i_araddr=0x1FC0_0020, i_arlen=7, 8 beats 0xA0..0xA7 with rlast on beat 8.
  - i_arready pulses once; m_arid=0, m_arlen=7, m_arburst=01.
  - The instruction client receives all 8 beats in order; the data client's rvalid stays 0; err=0.
- Simultaneous requests from reset: data granted first. After its rlast, instruction is granted at the earliest slot (arready one cycle after the rlast handshake). m_arid sequence is 1 then 0.
- Back-pressure: i_rready toggled 1,0,0,1 during a 4-beat burst.
  - m_rready mirrors i_rready exactly.
  - Data is held while the client is not ready; no beats are lost or duplicated.
- Protocol errors:
  - m_rlast on beat 3 of arlen=7: err=1, FSM returns to IDLE, next request still served.
  - Separate run with a wrong m_rid: err=1.
- Reset during beat 4 of 8: all outputs at reset values in the same cycle. After release, a fresh instruction request completes normally.

Source files
------------

// File: rtl/cache_axi_rd_arb_pkg.sv
// Shared encodings and AXI constants for the I/D-cache read-channel arbiter.
package cache_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AR   = 2'b01,
    R    = 2'b10
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int DEF_INST_ID = 0;
  localparam int DEF_DATA_ID = 1;

endpackage

// File: rtl/cache_axi_rd_arb_rr_arb2.sv
// Two-way round-robin grant; bit 0 is the instruction client, bit 1 the data client.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0: instruction granted last, 1: data granted last
  logic last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_grant <= 1'b0;
    else if (advance) last_grant <= gnt[1];
  end

endmodule

// File: rtl/cache_axi_rd_arb.sv
// Single-outstanding AXI4 read arbiter between I-cache and D-cache refill ports,
// with R-beat routing and a sticky burst-length / ID / response checker.
module cache_axi_rd_arb
  import cache_axi_rd_arb_pkg::*;
#(
  parameter int              ID_W    = 4,
  parameter logic [ID_W-1:0] INST_ID = ID_W'(DEF_INST_ID),
  parameter logic [ID_W-1:0] DATA_ID = ID_W'(DEF_DATA_ID)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     i_araddr,
  input  logic [7:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic            i_arvalid,
  output logic            i_arready,
  output logic [31:0]     i_rdata,
  output logic            i_rlast,
  output logic            i_rvalid,
  input  logic            i_rready,
  input  logic [31:0]     d_araddr,
  input  logic [7:0]      d_arlen,
  input  logic [2:0]      d_arsize,
  input  logic            d_arvalid,
  output logic            d_arready,
  output logic [31:0]     d_rdata,
  output logic            d_rlast,
  output logic            d_rvalid,
  input  logic            d_rready,
  output logic [ID_W-1:0] m_arid,
  output logic [31:0]     m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic            err
);

  state_t     state;
  logic       owner;   // 1: data client owns the outstanding burst
  logic [7:0] cnt;
  logic [1:0] gnt;
  logic       take;
  logic       in_r;
  logic       hs;
  logic       beat_err;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_arvalid, i_arvalid}),
    .advance (take),
    .gnt     (gnt)
  );

  assign take      = (state == IDLE) && (|gnt);
  assign i_arready = rst && take && gnt[0];
  assign d_arready = rst && take && gnt[1];

  assign in_r     = (state == R);
  assign m_rready = in_r && (owner ? d_rready : i_rready);
  assign i_rvalid = in_r && !owner && m_rvalid;
  assign i_rlast  = in_r && !owner && m_rlast;
  assign d_rvalid = in_r && owner && m_rvalid;
  assign d_rlast  = in_r && owner && m_rlast;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  assign m_arburst = AXI_BURST_INCR;

  assign hs = in_r && m_rvalid && m_rready;
  // rlast must coincide exactly with the beat whose index equals the latched arlen
  assign beat_err = (m_rlast != (cnt == m_arlen)) || (m_rid != m_arid) ||
                    (m_rresp != AXI_RESP_OKAY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      if (hs && beat_err) err <= 1'b1;
      case (state)
        IDLE: begin
          if (take) begin
            owner     <= gnt[1];
            m_arid    <= gnt[1] ? DATA_ID  : INST_ID;
            m_araddr  <= gnt[1] ? d_araddr : i_araddr;
            m_arlen   <= gnt[1] ? d_arlen  : i_arlen;
            m_arsize  <= gnt[1] ? d_arsize : i_arsize;
            m_arvalid <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            cnt       <= '0;
            state     <= R;
          end
        end
        R: begin
          if (hs) begin
            cnt <= cnt + 8'd1;
            if (m_rlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arb.sv
// Scoreboard bench for cache_axi_rd_arb: expected AR fields and R beats are queued
// when driven by the bench's slave model and checked when the DUT presents them.
module tb_cache_axi_rd_arb;

  localparam logic [3:0] IID = 4'd0;
  localparam logic [3:0] DID = 4'd1;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct {
    bit          cl;
    logic [31:0] data;
    bit          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_araddr = '0, d_araddr = '0;
  logic [7:0]  i_arlen = '0, d_arlen = '0;
  logic [2:0]  i_arsize = '0, d_arsize = '0;
  logic        i_arvalid = 1'b0, d_arvalid = 1'b0;
  logic        i_arready, d_arready;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rlast, d_rlast, i_rvalid, d_rvalid;
  logic        i_rready = 1'b1, d_rready = 1'b1;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [3:0]  m_rid = '0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic        err;

  cache_axi_rd_arb dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err(err)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    i_acc = 0, d_acc = 0;
  int    i_beats = 0, d_beats = 0;
  int    t_last_hs = -100, t_i_ar = -100;
  bit    beat_phase = 1'b0;
  ar_t   ar_q[$];
  beat_t exp_q[$];
  bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // clients drop arvalid after their accept pulse
  initial forever begin
    @(negedge clk);
    if (i_arvalid && i_arready) begin i_acc++; @(posedge clk); #1 i_arvalid = 1'b0; end
  end
  initial forever begin
    @(negedge clk);
    if (d_arvalid && d_arready) begin d_acc++; @(posedge clk); #1 d_arvalid = 1'b0; end
  end

  task automatic pop_beat(input bit cl, input logic [31:0] data, input bit last);
    beat_t e;
    chk("beat_expected", 64'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("beat_client", cl, e.cl);
      chk("beat_data", data, e.data);
      chk("beat_last", last, e.last);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (i_rvalid && d_rvalid) chk("both_rvalid", 1, 0);
    if (!i_rvalid && i_rlast) chk("i_rlast_gated", i_rlast, 0);
    if (!d_rvalid && d_rlast) chk("d_rlast_gated", d_rlast, 0);
    if (i_rvalid && i_rready) begin i_beats++; pop_beat(1'b0, i_rdata, i_rlast); end
    if (d_rvalid && d_rready) begin d_beats++; pop_beat(1'b1, d_rdata, d_rlast); end
    if (m_rvalid && m_rready && m_rlast) t_last_hs = cyc;
    if (i_arready) t_i_ar = cyc;
  end

  task automatic issue(input bit cl, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s);
    ar_t e;
    e.id = cl ? DID : IID; e.addr = a; e.len = l; e.size = s;
    ar_q.push_back(e);
    if (cl) begin d_araddr = a; d_arlen = l; d_arsize = s; d_arvalid = 1'b1; end
    else    begin i_araddr = a; i_arlen = l; i_arsize = s; i_arvalid = 1'b1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_arvalid"}, m_arvalid, 0);
    chk({tag, "_m_rready"},  m_rready, 0);
    chk({tag, "_i_rvalid"},  i_rvalid, 0);
    chk({tag, "_i_rlast"},   i_rlast, 0);
    chk({tag, "_d_rvalid"},  d_rvalid, 0);
    chk({tag, "_i_arready"}, i_arready, 0);
    chk({tag, "_m_araddr"},  m_araddr, 0);
    chk({tag, "_m_arlen"},   m_arlen, 0);
    chk({tag, "_m_arid"},    m_arid, 0);
    chk({tag, "_m_arburst"}, m_arburst, 2'b01);
    chk({tag, "_err"},       err, 0);
  endtask

  // AXI slave model: accept one AR, then return nb beats (rlast on the final one)
  task automatic serve(input int nb, input logic [31:0] base, input bit cl,
                       input logic [3:0] rid, input int abort_at);
    ar_t   e;
    beat_t b;
    int    w;
    w = 0;
    @(negedge clk);
    while (!m_arvalid && w < 50) begin @(negedge clk); w++; end
    chk("ar_wait", m_arvalid, 1);
    if (!m_arvalid) return;
    chk("ar_q_nonempty", 64'(ar_q.size() != 0), 1);
    if (ar_q.size() != 0) begin
      e = ar_q.pop_front();
      chk("m_arid", m_arid, e.id);
      chk("m_araddr", m_araddr, e.addr);
      chk("m_arlen", m_arlen, e.len);
      chk("m_arsize", m_arsize, e.size);
      chk("m_arburst", m_arburst, 2'b01);
    end
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    beat_phase = 1'b1;
    for (int k = 0; k < nb; k++) begin
      m_rvalid = 1'b1; m_rdata = base + 32'(k); m_rlast = (k == nb - 1); m_rid = rid;
      b.cl = cl; b.data = base + 32'(k); b.last = (k == nb - 1);
      exp_q.push_back(b);
      if (k == abort_at) begin
        #1 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        exp_q.delete();
        m_rvalid = 1'b0; m_rlast = 1'b0; beat_phase = 1'b0;
        return;
      end
      w = 0;
      do begin
        @(negedge clk);
        chk("rready_mirror", m_rready, cl ? d_rready : i_rready);
        w++;
      end while (!m_rready && w < 40);
      chk("beat_accept", m_rready, 1);
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; beat_phase = 1'b0;
  endtask

  initial begin
    int acc0, db0, ib0, td;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, db0, ib0, td;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_d_arready", d_arready, 0);
    rst = 1'b1;

    // instruction-only 8-beat burst
    acc0 = i_acc; db0 = d_beats; ib0 = i_beats;
    @(posedge clk); #1 issue(1'b0, 32'h1FC0_0020, 8'd7, 3'd2);
    serve(8, 32'hA0, 1'b0, IID, -1);
    @(negedge clk);
    chk("t1_i_arready_pulses", i_acc - acc0, 1);
    chk("t1_i_beats", i_beats - ib0, 8);
    chk("t1_d_beats", d_beats - db0, 0);
    chk("t1_err", err, 0);

    // simultaneous requests: data wins the first tie, inst follows at the earliest slot
    @(posedge clk); #1;
    issue(1'b1, 32'h0000_2000, 8'd1, 3'd2);
    issue(1'b0, 32'h0000_1000, 8'd3, 3'd2);
    serve(2, 32'hD0, 1'b1, DID, -1);
    td = t_last_hs;
    serve(4, 32'hB0, 1'b0, IID, -1);
    chk("t2_inst_grant_slot", 64'(t_i_ar - td), 1);

    // back-pressure 1,0,0,1 on the instruction client
    ib0 = i_beats;
    @(posedge clk); #1 issue(1'b0, 32'h0000_4000, 8'd3, 3'd2);
    fork
      serve(4, 32'hC0, 1'b0, IID, -1);
      begin
        wait (beat_phase);
        for (int k = 0; k < 4; k++) begin i_rready = pat[k]; @(posedge clk); #1; end
        i_rready = 1'b1;
      end
    join
    chk("t3_i_beats", i_beats - ib0, 4);
    chk("t3_err", err, 0);

    // early rlast on beat 3 of an 8-beat burst
    @(posedge clk); #1 issue(1'b0, 32'h0000_3000, 8'd7, 3'd2);
    serve(3, 32'hE0, 1'b0, IID, -1);
    @(negedge clk);
    chk("t4_err_early_last", err, 1);
    db0 = d_beats;
    @(posedge clk); #1 issue(1'b1, 32'h0000_5000, 8'd0, 3'd2);
    serve(1, 32'hF0, 1'b1, DID, -1);
    @(negedge clk);
    chk("t4_next_served", d_beats - db0, 1);
    chk("t4_err_sticky", err, 1);

    // wrong RID in a fresh run
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", err, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 issue(1'b0, 32'h0000_6000, 8'd1, 3'd2);
    serve(2, 32'h50, 1'b0, 4'h5, -1);
    @(negedge clk);
    chk("t5_err_bad_rid", err, 1);

    // reset during beat 4 of 8, then a fresh burst
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 issue(1'b0, 32'h0000_7000, 8'd7, 3'd2);
    serve(8, 32'h60, 1'b0, IID, 3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ib0 = i_beats;
    @(posedge clk); #1 issue(1'b0, 32'h0000_8000, 8'd1, 3'd2);
    serve(2, 32'h70, 1'b0, IID, -1);
    @(negedge clk);
    chk("t6_fresh_beats", i_beats - ib0, 2);
    chk("t6_err", err, 0);

    chk("end_beats_pending", exp_q.size(), 0);
    chk("end_ar_pending", ar_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
